// File: rtl/sys_arr_row_db_if.sv
`default_nettype none
// ============================================================================
//  Module   : sys_arr_row_db_if
//  Brief    : Bundle of operand, weight-load and handshake signals for one
//             double-buffered systolic-array row.
//  Revision : 1.0 - initial release
// ============================================================================
interface sys_arr_row_db_if #(
    parameter int ROW_WIDTH = 4,
    parameter int DATA_W    = 8,
    parameter int GUARD_W   = 4
);
    localparam int SUM_W = 2 * DATA_W + GUARD_W;

    logic                       active;
    logic [DATA_W-1:0]          datain;
    logic [ROW_WIDTH*SUM_W-1:0] sumin;
    logic                       wload;
    logic [DATA_W-1:0]          wdata;
    logic                       wswap;
    logic [ROW_WIDTH*SUM_W-1:0] maccout;
    logic [ROW_WIDTH-1:0]       activeout;
    logic [DATA_W-1:0]          dataout;
    logic                       ready;
    logic                       swap_done;
    logic                       err;

    // Row side: consumes operands and weights, produces results and status
    modport slave (
        input  active, datain, sumin, wload, wdata, wswap,
        output maccout, activeout, dataout, ready, swap_done, err
    );

    // Feeder side: drives operands and weights, observes results and status
    modport master (
        output active, datain, sumin, wload, wdata, wswap,
        input  maccout, activeout, dataout, ready, swap_done, err
    );
endinterface
`default_nettype wire

// File: rtl/sys_arr_row_db.sv
`default_nettype none
// ============================================================================
//  Module   : sys_arr_row_db
//  Brief    : Systolic-array row of ROW_WIDTH signed MAC PEs with
//             double-buffered weights. Shadow weights shift in serially while
//             the row computes; a drain-and-swap FSM commits them atomically
//             once no token is left in flight.
//  Options  : SYSROW_SAT_EN - when defined, each PE add saturates to the
//             SUM_W signed range; otherwise it wraps two's-complement.
//  Revision : 1.0 - initial release
// ============================================================================
module sys_arr_row_db #(
    parameter int ROW_WIDTH = 4,
    parameter int DATA_W    = 8,
    parameter int GUARD_W   = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    sys_arr_row_db_if.slave    bus
);
    localparam int SUM_W = 2 * DATA_W + GUARD_W;
    localparam int CNT_W = $clog2(ROW_WIDTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(ROW_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  data_q   [ROW_WIDTH];
    logic signed [DATA_W-1:0]  data_d   [ROW_WIDTH];
    logic signed [SUM_W-1:0]   macc_q   [ROW_WIDTH];
    logic signed [SUM_W-1:0]   macc_d   [ROW_WIDTH];
    logic signed [DATA_W-1:0]  wact_q   [ROW_WIDTH];
    logic signed [DATA_W-1:0]  wact_d   [ROW_WIDTH];
    logic signed [DATA_W-1:0]  shadow_q [ROW_WIDTH];
    logic signed [DATA_W-1:0]  shadow_d [ROW_WIDTH];
    logic [ROW_WIDTH-1:0]      act_q, act_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      err_q, err_d;

    logic                      w_ready;
    logic                      w_full;
    logic                      w_wload_acc;
    logic [ROW_WIDTH-1:0]      w_tok;
    logic signed [DATA_W-1:0]  w_din [ROW_WIDTH];
    logic signed [SUM_W-1:0]   w_sum [ROW_WIDTH];
    logic [ROW_WIDTH*SUM_W-1:0] w_maccout;

    assign w_ready     = (state_q == ST_IDLE);
    assign w_full      = (count_q == C_FULL);
    assign w_wload_acc = bus.wload & w_ready;

    // Per-PE token source, operand source and multiply-accumulate
    for (genvar gi = 0; gi < ROW_WIDTH; gi++) begin : g_pe
        logic signed [2*DATA_W-1:0] w_prod;
        logic signed [SUM_W-1:0]    w_prod_ext;
        logic signed [SUM_W-1:0]    w_sumin;

        if (gi == 0) begin : g_head
            assign w_tok[gi] = bus.active & w_ready;
            assign w_din[gi] = $signed(bus.datain);
        end else begin : g_body
            assign w_tok[gi] = act_q[gi-1];
            assign w_din[gi] = data_q[gi-1];
        end

        assign w_prod     = w_din[gi] * wact_q[gi];
        assign w_prod_ext = {{GUARD_W{w_prod[2*DATA_W-1]}}, w_prod};
        assign w_sumin    = $signed(bus.sumin[gi*SUM_W +: SUM_W]);

`ifdef SYSROW_SAT_EN
        logic signed [SUM_W:0]   w_wide;
        logic signed [SUM_W-1:0] w_sat;
        assign w_wide = {w_sumin[SUM_W-1], w_sumin} + {w_prod_ext[SUM_W-1], w_prod_ext};

        // Clamp to the signed SUM_W range when the extra carry disagrees with the sign
        always_comb begin
            w_sat = w_wide[SUM_W-1:0];
            if (w_wide[SUM_W] != w_wide[SUM_W-1]) begin
                w_sat = w_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}}
                                      : {1'b0, {(SUM_W-1){1'b1}}};
            end
        end
        assign w_sum[gi] = w_sat;
`else
        assign w_sum[gi] = w_sumin + w_prod_ext;
`endif
    end

    // Datapath next state: pipeline advance, shadow shift and atomic weight commit
    always_comb begin
        act_d   = w_tok;
        count_d = count_q;
        for (int i = 0; i < ROW_WIDTH; i++) begin
            data_d[i]   = data_q[i];
            macc_d[i]   = macc_q[i];
            wact_d[i]   = wact_q[i];
            shadow_d[i] = shadow_q[i];
            if (w_tok[i]) begin
                data_d[i] = w_din[i];
                macc_d[i] = w_sum[i];
            end
            if (state_q == ST_SWAP) begin
                wact_d[i] = shadow_q[i];
            end
            if (w_wload_acc) begin
                shadow_d[i] = (i == 0) ? $signed(bus.wdata) : shadow_q[(i == 0) ? 0 : i-1];
            end
        end
        if (state_q == ST_SWAP) begin
            count_d = '0;
        end else if (w_wload_acc && !w_full) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Drain-and-swap control plus sticky protocol-error detection
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wswap) begin
                    if (w_full) state_d = ST_DRAIN;
                    else        err_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (act_q == '0) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!w_ready && (bus.active || bus.wload)) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < ROW_WIDTH; i++) begin
                data_q[i]   <= '0;
                macc_q[i]   <= '0;
                wact_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int i = 0; i < ROW_WIDTH; i++) begin
                data_q[i]   <= data_d[i];
                macc_q[i]   <= macc_d[i];
                wact_q[i]   <= wact_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Flatten per-PE results onto the output bus
    always_comb begin
        w_maccout = '0;
        for (int i = 0; i < ROW_WIDTH; i++) begin
            w_maccout[i*SUM_W +: SUM_W] = macc_q[i];
        end
    end

    assign bus.maccout   = w_maccout;
    assign bus.activeout = act_q;
    assign bus.dataout   = data_q[ROW_WIDTH-1];
    assign bus.ready     = w_ready;
    assign bus.swap_done = (state_q == ST_SWAP);
    assign bus.err       = err_q;

endmodule
`default_nettype wire
